// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative divider and the control unit's DIV/DIVM wait states.
// DIV_ITER is the quotient-bit iteration count; results appear DIV_ITER+1 cycles after start.
package div_unit_pkg;

  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Iterative signed restoring divider: quotient to LO, remainder to HI (MIPS semantics).
// One quotient bit per cycle on magnitudes, sign correction in a final FIX cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_end,
  output logic             div_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // -2^(WIDTH-1) maps to the unsigned value 2^(WIDTH-1), which fits in WIDTH bits.
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = x;
    if (x[WIDTH-1]) r = ~r + WIDTH'(1);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x + WIDTH'(1)) : x;
  endfunction

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               end_q, end_d;
  logic               zero_q, zero_d;

  logic signed [WIDTH-1:0] sd, sv;
  logic [WIDTH:0]          rem_sh;
  logic                    rem_ge;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    end_d     = 1'b0;
    zero_d    = 1'b0;

    sd     = dividend;
    sv     = divisor;
    rem_sh = {acc_q, quo_q[WIDTH-1]};
    rem_ge = (rem_sh >= {1'b0, dvsr_q});

    unique case (state_q)
      ST_IDLE: begin
        if (div_start) begin
          if (divisor == '0) begin
            zero_d = 1'b1;
          end else begin
            dvsr_d    = abs_val(sv);
            quo_d     = abs_val(sd);
            acc_d     = '0;
            neg_quo_d = sd[WIDTH-1] ^ sv[WIDTH-1];
            neg_rem_d = sd[WIDTH-1];
            cnt_d     = CNT_W'(WIDTH);
            state_d   = ST_RUN;
          end
        end
      end
      // ---- restoring iteration: shift {acc,quo}, trial-subtract the divisor ----
      ST_RUN: begin
        if (rem_ge) begin
          acc_d = WIDTH'(rem_sh - {1'b0, dvsr_q});
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
      end
      // ---- sign fix-up and result publish ----
      ST_FIX: begin
        lo_d    = cond_neg(quo_q, neg_quo_q);
        hi_d    = cond_neg(acc_q, neg_rem_q);
        end_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      end_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      end_q     <= end_d;
      zero_q    <= zero_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign div_end  = end_q;
  assign div_zero = zero_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed operand pairs with hand-computed quotient/remainder,
// plus reset-in-flight, ignored restart, and divide-by-zero cases.
module tb_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         div_start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;
  logic         div_end;
  logic         div_zero;
  logic         busy;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .div_start (div_start),
    .dividend  (dividend),
    .divisor   (divisor),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .div_end   (div_end),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  typedef struct {
    string        nm;
    logic         zero;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } exp_t;

  exp_t         sbq[$];
  int           n_chk  = 0;
  int           n_pass = 0;
  logic [W-1:0] m_lo   = '0;
  logic [W-1:0] m_hi   = '0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Monitor: every result pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (div_end || div_zero)) begin
      chk("end_zero_exclusive", W'(div_end & div_zero), '0);
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_result: got end=%0b zero=%0b lo=0x%08h hi=0x%08h with none outstanding",
                 div_end, div_zero, lo_out, hi_out);
      end else begin
        e = sbq.pop_front();
        chk({e.nm, " kind_div_zero"}, W'(div_zero), W'(e.zero));
        chk({e.nm, " lo"}, lo_out, e.lo);
        chk({e.nm, " hi"}, hi_out, e.hi);
      end
    end
  end

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                        input int restart_at);
    exp_t         e;
    int           lat;
    int           bcnt;
    logic [W-1:0] prev_lo;
    logic [W-1:0] prev_hi;
    prev_lo = m_lo;
    prev_hi = m_hi;
    e.nm   = nm;
    e.zero = (b == '0);
    e.lo   = e.zero ? m_lo : exp_lo;
    e.hi   = e.zero ? m_hi : exp_hi;
    if (!e.zero) begin
      m_lo = exp_lo;
      m_hi = exp_hi;
    end
    sbq.push_back(e);

    @(negedge clk);
    dividend  = a;
    divisor   = b;
    div_start = 1'b1;
    lat  = -1;
    bcnt = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) begin
        div_start = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
      end
      if (restart_at != 0 && i == restart_at) begin
        div_start = 1'b1;
        dividend  = 32'd55;
        divisor   = 32'd5;
      end
      if (restart_at != 0 && i == restart_at + 1) div_start = 1'b0;
      if (i == 10 && !e.zero) begin
        chk({nm, " lo_held_in_run"}, lo_out, prev_lo);
        chk({nm, " hi_held_in_run"}, hi_out, prev_hi);
      end
      if (busy) bcnt++;
      if (div_end || div_zero) begin
        lat = i - 1;
        break;
      end
    end
    if (lat < 0) begin
      n_chk++;
      $display("FAIL %s timeout: no div_end/div_zero within 60 cycles", nm);
    end else begin
      chk({nm, " latency"}, lat, e.zero ? 0 : W + 1);
      chk({nm, " busy_cycles"}, bcnt, e.zero ? 0 : W + 1);
      @(negedge clk);
      chk({nm, " pulse_one_cycle"}, W'(div_end | div_zero), '0);
    end
  endtask

  initial begin
    logic signed [W-1:0] sa, sv;
    logic [W-1:0]        ra, rb;

    reset     = 1'b1;
    div_start = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("reset hi_out", hi_out, '0);
    chk("reset lo_out", lo_out, '0);
    chk("reset flags", {29'd0, busy, div_end, div_zero}, '0);
    reset = 1'b0;
    @(negedge clk);

    run_op("7/2",                32'd7,        32'd2,        32'd3,        32'd1,        0);
    run_op("-7/2",               32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 0);
    run_op("7/-2",               32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        0);
    run_op("-7/-2",              32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 0);
    run_op("100/0",              32'd100,      32'd0,        32'd0,        32'd0,        0);
    run_op("min/-1",             32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        0);
    run_op("0/5",                32'd0,        32'd5,        32'd0,        32'd0,        0);
    run_op("5/7",                32'd5,        32'd7,        32'd0,        32'd5,        0);
    run_op("max/1",              32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        0);
    run_op("min/2",              32'h80000000, 32'd2,        32'hC0000000, 32'd0,        0);
    run_op("-1/min",             32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF, 0);
    run_op("min/min",            32'h80000000, 32'h80000000, 32'd1,        32'd0,        0);
    run_op("1000/7",             32'd1000,     32'd7,        32'd142,      32'd6,        0);
    run_op("-1/0",               32'hFFFFFFFF, 32'd0,        32'd0,        32'd0,        0);
    run_op("1000/7 restart_ign", 32'd1000,     32'd7,        32'd142,      32'd6,        6);

    // Abort a division mid-run; outputs must clear asynchronously and no pulse may follow.
    @(negedge clk);
    dividend  = 32'd123456;
    divisor   = 32'd7;
    div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset hi_out", hi_out, '0);
    chk("async_reset lo_out", lo_out, '0);
    chk("async_reset busy", W'(busy), '0);
    @(negedge clk);
    reset = 1'b0;
    m_lo  = '0;
    m_hi  = '0;
    repeat (40) @(negedge clk);
    chk("after_reset busy", W'(busy), '0);
    run_op("9/3 after reset", 32'd9, 32'd3, 32'd3, 32'd0, 0);

    for (int k = 0; k < 20; k++) begin
      ra = $urandom;
      rb = (k % 2 == 0) ? $urandom_range(1, 40) : $urandom;
      if (k % 4 == 1) rb = ~rb + 32'd1;
      if (rb == '0) rb = 32'd3;
      if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) ra = 32'd17;
      sa = ra;
      sv = rb;
      run_op($sformatf("rand%0d", k), ra, rb, sa / sv, sa % sv, 0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
